// File: rtl/div_pkg.sv
// Shared definitions for the unsigned-divider result collector.
package div_pkg;

    localparam int DIV_D_WIDTH = 8;

    typedef struct packed {
        logic [DIV_D_WIDTH-1:0] q;
        logic [DIV_D_WIDTH-1:0] s;
        logic                   div0;
        logic                   ovf;
    } div_result_t;

endpackage

// File: rtl/div_collect_fifo.sv
// Result buffer for div_uu_collect: power-of-two depth, occupancy count output.
module div_collect_fifo import div_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2 * DIV_D_WIDTH + 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_pop;

    assign do_pop = pop && (count != '0);
    assign rdata  = mem[rptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + AW'(1);
            if (do_pop)
                rptr <= rptr + AW'(1);
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= wdata;
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count == FULL_C)));

endmodule

// File: rtl/div_uu_collect.sv
// Collects pipelined divider results into an in-order buffer with credit flow control.
// Optional macro DIV_COLLECT_ERR_CNT_EN enables the saturating div0|ovf counter on err_cnt.
module div_uu_collect import div_pkg::*; #(
    parameter int D_WIDTH    = DIV_D_WIDTH,
    parameter int LATENCY    = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               div_ena,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [D_WIDTH-1:0] q,
    input  logic [D_WIDTH-1:0] s,
    input  logic               div0,
    input  logic               ovf,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] out_q,
    output logic [D_WIDTH-1:0] out_s,
    output logic               out_div0,
    output logic               out_ovf,
    output logic [7:0]         err_cnt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int RW = 2 * D_WIDTH + 2;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    logic [CW-1:0]      fifo_count;
    logic [CW-1:0]      inflight;
    logic [CW:0]        credit_used;
    logic               accept;
    logic               capture;
    logic               acc_p0;
    logic [LATENCY-1:0] vld_sr;
    logic [RW-1:0]      head;

    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
    assign in_ready    = div_ena && (credit_used < DEPTH_C);
    assign accept      = in_valid && in_ready;
    assign capture     = vld_sr[LATENCY-1] && div_ena;

    // acc_p0 marks the divider's operand-sample edge; vld_sr then counts the
    // LATENCY ena-qualified edges until q/s are valid on the divider outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_p0 <= 1'b0;
            vld_sr <= '0;
        end else if (div_ena) begin
            acc_p0 <= accept;
            vld_sr <= (vld_sr << 1) | LATENCY'(acc_p0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            inflight <= '0;
        else begin
            case ({accept, capture})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    div_collect_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (capture),
        .wdata ({q, s, div0, ovf}),
        .pop   (out_valid && out_ready),
        .rdata (head),
        .count (fifo_count)
    );

    // Head is masked while empty so the outputs read zero out of reset.
    assign out_valid = (fifo_count != '0);
    assign {out_q, out_s, out_div0, out_ovf} = out_valid ? head : '0;

`ifdef DIV_COLLECT_ERR_CNT_EN
    logic [7:0] err_cnt_r;

    always_ff @(posedge clk) begin
        if (!rst_n)
            err_cnt_r <= 8'd0;
        else if (capture && (div0 || ovf) && (err_cnt_r != 8'hFF))
            err_cnt_r <= err_cnt_r + 8'd1;
    end

    assign err_cnt = err_cnt_r;
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_div_uu_collect.sv
// Bench for div_uu_collect: behavioural divider model, scoreboard queue, decoupled monitor.
module tb_div_uu_collect;
    import div_pkg::*;

    localparam int LAT = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        div_ena = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] z = 16'd0;
    logic [7:0]  d = 8'd1;
    logic [7:0]  q, s, out_q, out_s, err_cnt;
    logic        div0, ovf, in_ready, out_valid, out_div0, out_ovf;

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    int err_model = 0;
    div_result_t expq[$];
    div_result_t mon_e;
    div_result_t dout;

    logic [15:0] pz [LAT+1];
    logic [7:0]  pd [LAT+1];

    div_uu_collect #(.D_WIDTH(8), .LATENCY(LAT), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .div_ena(div_ena), .in_valid(in_valid),
        .in_ready(in_ready), .q(q), .s(s), .div0(div0), .ovf(ovf),
        .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_s(out_s),
        .out_div0(out_div0), .out_ovf(out_ovf), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic div_result_t divref(input logic [15:0] zz, input logic [7:0] dd);
        div_result_t r;
        int quo, rem;
        if (dd == 8'd0) begin
            r.q = 8'hFF; r.s = zz[7:0]; r.div0 = 1'b1; r.ovf = 1'b0;
        end else begin
            quo = int'(zz) / int'(dd);
            rem = int'(zz) % int'(dd);
            r.q = quo[7:0]; r.s = rem[7:0]; r.div0 = 1'b0; r.ovf = (quo > 255);
        end
        return r;
    endfunction

    // External divider: operands sampled on an ena edge appear LAT ena edges later.
    always @(posedge clk) begin
        if (div_ena) begin
            pz[0] <= z;
            pd[0] <= d;
            for (int i = 1; i <= LAT; i++) begin
                pz[i] <= pz[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end
    assign dout = divref(pz[LAT], pd[LAT]);
    assign q = dout.q;
    assign s = dout.s;
    assign div0 = dout.div0;
    assign ovf = dout.ovf;

    function automatic int err_exp();
`ifdef DIV_COLLECT_ERR_CNT_EN
        return (err_model > 255) ? 255 : err_model;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [15:0] zz, input logic [7:0] dd, input logic en);
        div_result_t r;
        @(negedge clk);
        in_valid = v; z = zz; d = dd; div_ena = en;
        #1;
        if (in_valid && in_ready) begin
            r = divref(zz, dd);
            expq.push_back(r);
            acc_cnt++;
            if (r.div0 || r.ovf) err_model++;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        expq.delete();
        err_model = 0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int i = 0; i < 200 && expq.size() != 0; i++)
            cyc(1'b0, 16'd0, 8'd0, 1'b1);
        cyc(1'b0, 16'd0, 8'd0, 1'b1);
        chk({name, "_drained"}, expq.size(), 0);
        chk({name, "_err_cnt"}, int'(err_cnt), err_exp());
    endtask

    // Monitor: every accepted head must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL stale_result: got q=%h s=%h div0=%b ovf=%b with nothing outstanding",
                             out_q, out_s, out_div0, out_ovf);
                end else begin
                    mon_e = expq.pop_front();
                    if ({out_q, out_s, out_div0, out_ovf} !== mon_e) begin
                        errors++;
                        $display("FAIL result: got q=%h s=%h div0=%b ovf=%b expected q=%h s=%h div0=%b ovf=%b",
                                 out_q, out_s, out_div0, out_ovf, mon_e.q, mon_e.s, mon_e.div0, mon_e.ovf);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int stale;
        logic [15:0] rz;
        logic [7:0]  rd;

        // Reset state
        do_reset(2);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_q", int'(out_q), 0);
        chk("rst_out_s", int'(out_s), 0);
        chk("rst_out_flags", int'({out_div0, out_ovf}), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        // Single-op latency: valid appears exactly after edge N+10
        cyc(1'b1, 16'h00FF, 8'h01, 1'b1);
        for (int k = 0; k <= 10; k++) begin
            cyc(1'b0, 16'h0000, 8'h00, 1'b1);
            chk($sformatf("lat_valid_k%0d", k), int'(out_valid), int'(k == 10));
            if (k == 10) chk("lat_q", int'(out_q), 8'hFF);
        end
        drain("lat");

        // Divide by zero and quotient overflow
        cyc(1'b1, 16'h0064, 8'h00, 1'b1);
        drain("div0");
        cyc(1'b1, 16'h1234, 8'h10, 1'b1);
        drain("ovf");

        // Back-pressure: credits cap acceptance at the buffer depth
        out_ready = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 6; i++)
            cyc(1'b1, 16'($urandom), 8'($urandom_range(1, 255)), 1'b1);
        chk("bp_accepts", acc_cnt, 4);
        cyc(1'b0, 16'd0, 8'd0, 1'b1);
        chk("bp_in_ready_low", int'(in_ready), 0);
        repeat (12) cyc(1'b0, 16'd0, 8'd0, 1'b1);
        chk("bp_full_valid", int'(out_valid), 1);
        chk("bp_full_in_ready", int'(in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 16'd0, 8'd0, 1'b1);
            chk($sformatf("bp_head_q_%0d", i), int'(out_q), int'(expq[0].q));
            chk($sformatf("bp_head_s_%0d", i), int'(out_s), int'(expq[0].s));
        end
        drain("bp");
        acc_cnt = 0;
        cyc(1'b1, 16'h0F00, 8'h20, 1'b1);
        chk("bp_resume", acc_cnt, 1);
        drain("resume");

        // Enable stall of 3 edges mid-flight delays capture by 3 edges
        rz = 16'($urandom_range(0, 4095));
        rd = 8'($urandom_range(16, 255));
        cyc(1'b1, rz, rd, 1'b1);
        for (int k = 0; k <= 13; k++) begin
            cyc(1'b0, 16'd0, 8'd0, !(k >= 3 && k <= 5));
            chk($sformatf("stall_valid_k%0d", k), int'(out_valid), int'(k == 13));
        end
        drain("stall");

        // Reset with three operations in flight: nothing stale may surface
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 16'($urandom), 8'($urandom_range(0, 255)), 1'b1);
        cyc(1'b0, 16'd0, 8'd0, 1'b1);
        cyc(1'b0, 16'd0, 8'd0, 1'b1);
        do_reset(1);
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_err_cnt", int'(err_cnt), 0);
        stale = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 16'd0, 8'd0, 1'b1);
            if (out_valid) stale++;
        end
        chk("midrst_no_stale", stale, 0);
        out_ready = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 6; i++)
            cyc(1'b1, 16'($urandom), 8'($urandom_range(1, 255)), 1'b1);
        chk("midrst_credits", acc_cnt, 4);
        drain("midrst");

        // Error counter saturation
        do_reset(1);
        for (int i = 0; i < 3000 && err_model < 260; i++)
            cyc(1'b1, 16'($urandom), 8'd0, 1'b1);
        drain("sat");

        // Randomised traffic with random enable and back-pressure
        do_reset(1);
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 99) < 70);
            cyc(($urandom_range(0, 99) < 60),
                16'($urandom_range(0, 65535) >> $urandom_range(0, 8)),
                8'($urandom_range(0, 255)),
                ($urandom_range(0, 99) < 85));
        end
        drain("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_uu_collect.md
DIV_UU_COLLECT -- requirements
Module: div_uu_collect

Interface
REQ-001 Parameters SHALL be:
- D_WIDTH, default 8, quotient/remainder width; matches divider d_width.
- LATENCY, default 9, ena-qualified edges from divider operand sample to valid q/s; >=1.
- FIFO_DEPTH, default 4, result buffer entries; power of 2, >=2.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- div_ena  in  1  same signal that drives the divider ena.
- in_valid  in  1  upstream presents operands to the divider this cycle.
- in_ready  out  1  operands are accepted this cycle.
- q  in  D_WIDTH  divider quotient.
- s  in  D_WIDTH  divider remainder.
- div0  in  1  divider divide-by-zero flag.
- ovf  in  1  divider overflow flag.
- out_valid  out  1  result available at head.
- out_ready  in  1  consumer accepts head.
- out_q  out  D_WIDTH  head quotient.
- out_s  out  D_WIDTH  head remainder.
- out_div0  out  1  head div0.
- out_ovf  out  1  head ovf.
- err_cnt  out  8  count of div0|ovf results.

Function
REQ-003 Accept SHALL be defined as in_valid && in_ready; in_ready = div_ena && (fifo_count + inflight < FIFO_DEPTH), from registered state only.
REQ-004 A LATENCY-bit valid shift register SHALL advance only on edges with div_ena=1; bit 0 loads accept.
REQ-005 While the tail bit is 1 and div_ena=1, the next edge SHALL push {q,s,div0,ovf} into the FIFO (capture); for an accept at edge N with div_ena constantly 1, capture occurs at edge N+LATENCY+1.
REQ-006 inflight SHALL increment on accept and decrement on capture; when both occur in the same cycle it SHALL be unchanged.
REQ-007 Credit rule SHALL guarantee that a push never finds the FIFO full; a push into a full FIFO is a design error flagged by a simulation assertion.
REQ-008 out_valid SHALL equal FIFO non-empty; pop on out_valid && out_ready; simultaneous push and pop SHALL keep the count and preserve order.
REQ-009 Head data SHALL remain stable while out_valid && !out_ready.
REQ-010 Results SHALL leave in strict issue order.
REQ-011 div_ena=0 SHALL freeze the shift register and block accept; FIFO pops continue.

Reset
REQ-012 With rst_n=0 at an edge, the following SHALL be cleared: shift register, inflight, FIFO pointers/count, err_cnt.
- Resulting outputs: out_valid=0, out_q=0, out_s=0, out_div0=0, out_ovf=0, err_cnt=0.
REQ-013 Results already in the divider pipeline at reset SHALL be discarded, never captured.
REQ-014 in_ready SHALL follow REQ-003 from the first cycle after reset release (1 if div_ena=1).

Configuration
REQ-015 With DIV_COLLECT_ERR_CNT_EN defined, err_cnt SHALL increment by 1 on each capture with div0|ovf, saturate at 255, and clear on reset.
REQ-016 Without DIV_COLLECT_ERR_CNT_EN, err_cnt SHALL be constant 0 with no counter logic.

Structure
REQ-017 The shared package div_pkg SHALL hold the D_WIDTH default and the result struct {q,s,div0,ovf}.
REQ-018 The FIFO SHALL be a sub-module, div_collect_fifo (parameterised depth and width, count output); the credit logic and shift register remain in the top.

Verification
REQ-019 z=16'h00FF, d=8'h01, one accept at edge N, out_ready=1 -> out_valid after edge N+10 (LATENCY=9), out_q=8'hFF, out_s=0, div0=0, ovf=0.
REQ-020 z=16'h0064, d=8'h00 -> out_div0=1; err_cnt=1 with the macro defined, 0 without.
REQ-021 z=16'h1234, d=8'h10 (quotient 0x123 exceeds 8 bits) -> out_ovf=1, err_cnt increments.
REQ-022 6 back-to-back in_valid with out_ready=0 -> exactly 4 accepted, then in_ready=0. Raising out_ready -> 4 results in order, then accepts resume; nothing lost or duplicated.
REQ-023 div_ena=0 for 3 cycles mid-flight -> capture delayed by exactly 3 edges; values correct.
REQ-024 rst_n=0 for 1 edge with 3 operations in flight -> out_valid=0, inflight=0 next cycle; no stale result ever appears at the output.
